// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared symbol type, FSM states and constants for the JPEG RLE encoder
package jpeg_pkg;
  localparam int BLK_LEN = 64;
  localparam logic [3:0] ZRL_RUN = 4'd15;
  localparam int AMP_W = 16;
  typedef enum logic {ACCEPT, EMIT_ZRL} state_t;
  typedef struct packed {
    logic dc;
    logic eob;
    logic [3:0] run;
    logic [3:0] size;
    logic [AMP_W-1:0] amp;
  } sym_t;
endpackage

// File: rtl/jpeg_size_amp.sv
// jpeg_size_amp: combinational JPEG magnitude category (size) and one's-complement amplitude bits
module jpeg_size_amp #(
  parameter int W = 13
) (
  input  logic signed [W-1:0] val,
  output logic [3:0]          size,
  output logic [W-1:0]        amp
);
  logic [W-1:0] mag;
  assign mag = val[W-1] ? -val : val;
  always_comb begin
    size = '0;
    for (int i = 0; i < W; i++) if (mag[i]) size = 4'(i + 1);
  end
  assign amp = val[W-1] ? (val - W'(1)) & ~({W{1'b1}} << size) : val;
endmodule

// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder: zigzag coefficients in (one per cycle, 64 per block), DC/AC/ZRL/EOB symbols out
module jpeg_rle_encoder
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dc,
  output logic              out_eob,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W-1:0] out_amp
);
  state_t state, state_n;
  logic [5:0] idx, zrun, zrun_n;
  logic [COEF_W-1:0] pred, hold;
  logic signed [COEF_W:0] diff, sa_in;
  logic [3:0] sa_size;
  logic [COEF_W:0] sa_amp;
  sym_t sym, sym_n;
  logic load, fire, out_free, last, zrl_due;
  assign out_free = !out_valid || out_ready;
  assign in_ready = state == ACCEPT && out_free;
  assign fire = in_valid && in_ready;
  assign last = idx == 6'(BLK_LEN - 1);
  assign zrl_due = zrun >= 6'd16;
  assign diff = {in_coef[COEF_W-1], in_coef} - {pred[COEF_W-1], pred};
  // one size/amp unit shared: held AC coef during ZRL bursts, else DC diff or live AC coef
  assign sa_in = state == EMIT_ZRL ? {hold[COEF_W-1], hold} :
                 idx == 6'd0 ? diff : {in_coef[COEF_W-1], in_coef};
  jpeg_size_amp #(.W(COEF_W + 1)) u_size_amp (
    .val  (sa_in),
    .size (sa_size),
    .amp  (sa_amp)
  );
  always_comb begin
    state_n = state;
    zrun_n = zrun;
    load = 1'b0;
    sym_n = '0;
    if (fire) begin
      load = 1'b1;
      if (idx == 6'd0) begin
        sym_n.dc = 1'b1;
        sym_n.size = sa_size;
        sym_n.amp = AMP_W'(sa_amp);
      end else if (in_coef == '0) begin
        load = last;
        sym_n.eob = last;
        zrun_n = last ? 6'd0 : zrun + 6'd1;
      end else if (zrl_due) begin
        sym_n.run = ZRL_RUN;
        zrun_n = zrun - 6'd16;
        state_n = EMIT_ZRL;
      end else begin
        sym_n.run = zrun[3:0];
        sym_n.size = sa_size;
        sym_n.amp = AMP_W'(sa_amp);
        zrun_n = 6'd0;
      end
    end else if (state == EMIT_ZRL && out_free) begin
      load = 1'b1;
      sym_n.run = zrl_due ? ZRL_RUN : zrun[3:0];
      sym_n.size = zrl_due ? 4'd0 : sa_size;
      sym_n.amp = zrl_due ? '0 : AMP_W'(sa_amp);
      zrun_n = zrl_due ? zrun - 6'd16 : 6'd0;
      state_n = zrl_due ? EMIT_ZRL : ACCEPT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
      idx <= '0;
      zrun <= '0;
      pred <= '0;
      hold <= '0;
      sym <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      zrun <= zrun_n;
      if (fire) begin
        idx <= idx + 6'd1;
        hold <= in_coef;
        if (idx == 6'd0) pred <= in_coef;
      end
      if (load) begin
        sym <= sym_n;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
  assign out_dc = sym.dc;
  assign out_eob = sym.eob;
  assign out_run = sym.run;
  assign out_size = sym.size;
  assign out_amp = COEF_W'(sym.amp);
endmodule
